board_turn_controller: RTL and testbench

- Game sequencer for the 4x4 board shown by the VGA renderer.
- Accepts cell-selection moves and alternates players between them.
- Rejects moves into occupied cells, detects a four-in-a-line win or a draw, and holds a working board.
- Commits the working board to the display-facing board bus only on a VGA frame boundary (vsync falling edge), so the renderer never shows a half-updated frame.

---
 rtl/board_turn_controller_if.sv | 37 +++
 rtl/board_turn_controller.sv | 178 +++++++++++++++++
 tb/tb_board_turn_controller.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/board_turn_controller_if.sv
// Move/board handshake bundle between the game sequencer and its host.
// The host side drives moves and vsync; the sequencer returns board state.
interface board_turn_controller_if;
  logic        vsync;
  logic        new_game;
  logic        move_valid;
  logic [3:0]  casilla;
  logic        move_ready;
  logic        jugador;
  logic [63:0] board;
  logic [1:0]  status;
  logic        move_err;

  modport master (
    output vsync,
    output new_game,
    output move_valid,
    output casilla,
    input  move_ready,
    input  jugador,
    input  board,
    input  status,
    input  move_err
  );

  modport slave (
    input  vsync,
    input  new_game,
    input  move_valid,
    input  casilla,
    output move_ready,
    output jugador,
    output board,
    output status,
    output move_err
  );
endinterface

// File: rtl/board_turn_controller.sv
// 4x4 game sequencer: validates moves, detects win/draw and commits the
// working board to the display bus on a frame boundary.
module board_turn_controller #(
  parameter logic [3:0] P0_CODE       = 4'd1,
  parameter logic [3:0] P1_CODE       = 4'd2,
  parameter bit         SYNC_TO_VSYNC = 1'b1
) (
  input logic                    clk,
  input logic                    rst,
  board_turn_controller_if.slave bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CHECK  = 3'd1;
  localparam logic [2:0] S_EVAL   = 3'd2;
  localparam logic [2:0] S_COMMIT = 3'd3;
  localparam logic [2:0] S_OVER   = 3'd4;

  localparam logic [1:0] ST_PLAY = 2'b00;
  localparam logic [1:0] ST_P0   = 2'b01;
  localparam logic [1:0] ST_P1   = 2'b10;
  localparam logic [1:0] ST_DRAW = 2'b11;

  logic [2:0]  state_q, state_d;
  logic [3:0]  cell_q, cell_d;
  logic [63:0] wb_q, wb_d;
  logic [63:0] board_q, board_d;
  logic        jug_q, jug_d;
  logic [1:0]  st_q, st_d;
  logic        err_q, err_d;

  logic [1:0]  vs_q;
  logic        vs_prev_q;
  logic        frame;

  logic [3:0]  cl [16];
  logic [3:0]  win_code;
  logic        full;
  logic [5:0]  base;
  logic        occ;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vs_q      <= 2'b11;
      vs_prev_q <= 1'b1;
    end else begin
      vs_q      <= {vs_q[0], bus.vsync};
      vs_prev_q <= vs_q[1];
    end
  end

  assign frame = vs_prev_q & ~vs_q[1];

  function automatic logic same4(
    input logic [3:0] a,
    input logic [3:0] b,
    input logic [3:0] c,
    input logic [3:0] d
  );
    return (a != 4'd0) && (a == b) &&
           (b == c) && (c == d);
  endfunction

  always_comb begin
    for (int i = 0; i < 16; i++) begin
      cl[i] = wb_q[4*i +: 4];
    end
  end

  // rows and columns, then both diagonals
  always_comb begin
    win_code = 4'd0;
    full     = 1'b1;
    for (int i = 0; i < 16; i++) begin
      full = full & (cl[i] != 4'd0);
    end
    for (int k = 0; k < 4; k++) begin
      if (same4(cl[4*k], cl[4*k+1],
                cl[4*k+2], cl[4*k+3]))
        win_code = cl[4*k];
      if (same4(cl[k], cl[k+4],
                cl[k+8], cl[k+12]))
        win_code = cl[k];
    end
    if (same4(cl[0], cl[5], cl[10], cl[15]))
      win_code = cl[0];
    if (same4(cl[3], cl[6], cl[9], cl[12]))
      win_code = cl[3];
  end

  assign base = {cell_q, 2'b00};
  assign occ  = |wb_q[base +: 4];

  always_comb begin
    state_d = state_q;
    cell_d  = cell_q;
    wb_d    = wb_q;
    board_d = board_q;
    jug_d   = jug_q;
    st_d    = st_q;
    err_d   = 1'b0;
    if (bus.new_game) begin
      wb_d    = '0;
      st_d    = ST_PLAY;
      jug_d   = 1'b0;
      state_d = S_COMMIT;
    end else begin
      unique case (1'b1)
        state_q == S_IDLE: begin
          if (bus.move_valid) begin
            cell_d  = bus.casilla;
            state_d = S_CHECK;
          end
        end
        state_q == S_CHECK: begin
          if (occ) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            wb_d[base +: 4] = jug_q ? P1_CODE
                                    : P0_CODE;
            state_d = S_EVAL;
          end
        end
        state_q == S_EVAL: begin
          if (win_code != 4'd0)
            st_d = (win_code == P1_CODE) ? ST_P1
                                         : ST_P0;
          else if (full)
            st_d = ST_DRAW;
          else
            jug_d = ~jug_q;
          state_d = S_COMMIT;
        end
        state_q == S_COMMIT: begin
          if (!SYNC_TO_VSYNC || frame) begin
            board_d = wb_q;
            state_d = (st_q == ST_PLAY) ? S_IDLE
                                        : S_OVER;
          end
        end
        state_q == S_OVER: begin
          state_d = S_OVER;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cell_q  <= 4'd0;
      wb_q    <= '0;
      board_q <= '0;
      jug_q   <= 1'b0;
      st_q    <= ST_PLAY;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cell_q  <= cell_d;
      wb_q    <= wb_d;
      board_q <= board_d;
      jug_q   <= jug_d;
      st_q    <= st_d;
      err_q   <= err_d;
    end
  end

  assign bus.move_ready = (state_q == S_IDLE);
  assign bus.jugador    = jug_q;
  assign bus.board      = board_q;
  assign bus.status     = st_q;
  assign bus.move_err   = err_q;

endmodule

// File: tb/tb_board_turn_controller.sv
// Scoreboard bench for board_turn_controller: bypass and vsync-synced
// instances, expected outcomes queued per move and popped on completion.
module tb_board_turn_controller;

  typedef struct {
    logic        err;
    logic [63:0] board;
    logic        jug;
    logic [1:0]  st;
    logic        rdy;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  board_turn_controller_if b0();
  board_turn_controller_if b1();

  board_turn_controller #(
    .SYNC_TO_VSYNC(1'b0)
  ) u_byp (
    .clk(clk),
    .rst(rst),
    .bus(b0.slave)
  );

  board_turn_controller #(
    .SYNC_TO_VSYNC(1'b1)
  ) u_syn (
    .clk(clk),
    .rst(rst),
    .bus(b1.slave)
  );

  int   total = 0;
  int   bad   = 0;
  exp_t sbq[$];

  logic [3:0] mcell [16];
  logic       mjug;
  logic [1:0] mstat;
  int         last_lat;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h",
               tag, got, exp);
    end
  endtask

  function automatic logic [63:0] pack();
    logic [63:0] p;
    for (int i = 0; i < 16; i++)
      p[4*i +: 4] = mcell[i];
    return p;
  endfunction

  task automatic mreset();
    for (int i = 0; i < 16; i++) mcell[i] = 4'd0;
    mjug  = 1'b0;
    mstat = 2'b00;
  endtask

  // Called at a negedge with the bypass DUT idle.
  task automatic play(input int c,
                      input logic [1:0] st_ok);
    exp_t        e;
    exp_t        g;
    logic [63:0] prev;
    int          n;
    if (mcell[c] != 4'd0) begin
      e.err = 1'b1;
    end else begin
      e.err    = 1'b0;
      mcell[c] = mjug ? 4'd2 : 4'd1;
      mstat    = st_ok;
      if (st_ok == 2'b00) mjug = ~mjug;
    end
    e.board = pack();
    e.jug   = mjug;
    e.st    = mstat;
    e.rdy   = (mstat == 2'b00);
    sbq.push_back(e);
    prev = b0.board;
    b0.move_valid = 1'b1;
    b0.casilla    = c[3:0];
    @(negedge clk);
    b0.move_valid = 1'b0;
    n = 0;
    while (!(b0.move_err || b0.board != prev)
           && n < 12) begin
      @(negedge clk);
      n++;
    end
    last_lat = n;
    if (n >= 12) chk("move_timeout", 1, 0);
    g = sbq.pop_front();
    chk("err", b0.move_err, g.err);
    chk("board", b0.board, g.board);
    chk("jug", b0.jugador, g.jug);
    chk("status", b0.status, g.st);
    chk("ready", b0.move_ready, g.rdy);
    if (g.err) begin
      @(negedge clk);
      chk("err_pulse", b0.move_err, 0);
    end
  endtask

  task automatic new_game0();
    b0.new_game = 1'b1;
    @(negedge clk);
    b0.new_game = 1'b0;
    repeat (2) @(negedge clk);
    mreset();
    chk("ng_board", b0.board, pack());
    chk("ng_jug", b0.jugador, mjug);
    chk("ng_status", b0.status, mstat);
    chk("ng_ready", b0.move_ready, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: sim time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int          draw_ord [16];
    int          win_ord  [7];
    logic        seen;
    logic [63:0] prev;
    exp_t        e;
    exp_t        g;
    int          n;

    draw_ord = '{0, 2, 1, 3, 6, 4, 7, 5,
                 8, 10, 9, 11, 14, 12, 15, 13};
    win_ord  = '{0, 4, 1, 5, 2, 6, 3};

    rst = 1'b0;
    b0.vsync = 1'b1; b0.new_game = 1'b0;
    b0.move_valid = 1'b0; b0.casilla = 4'd0;
    b1.vsync = 1'b1; b1.new_game = 1'b0;
    b1.move_valid = 1'b0; b1.casilla = 4'd0;
    mreset();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    chk("rst_board", b0.board, 0);
    chk("rst_status", b0.status, 0);
    chk("rst_jug", b0.jugador, 0);
    chk("rst_ready", b0.move_ready, 1);
    chk("rst_err", b0.move_err, 0);
    chk("rst_board_s", b1.board, 0);

    play(5, 2'b00);
    chk("latency", last_lat, 3);
    chk("cell5", b0.board[23:20], 1);
    play(5, 2'b00);

    new_game0();
    for (int i = 0; i < 7; i++)
      play(win_ord[i], (i == 6) ? 2'b01 : 2'b00);
    chk("win_row0", b0.board[15:0], 16'h1111);

    seen = 1'b0;
    prev = b0.board;
    b0.move_valid = 1'b1;
    b0.casilla    = 4'd8;
    repeat (4) begin
      @(negedge clk);
      seen = seen | b0.move_err;
    end
    b0.move_valid = 1'b0;
    repeat (4) begin
      @(negedge clk);
      seen = seen | b0.move_err;
    end
    chk("over_noerr", seen, 0);
    chk("over_board", b0.board, prev);
    chk("over_ready", b0.move_ready, 0);
    chk("over_status", b0.status, 2'b01);

    new_game0();
    for (int i = 0; i < 16; i++)
      play(draw_ord[i], (i == 15) ? 2'b11 : 2'b00);
    chk("draw_jug", b0.jugador, 1);
    chk("draw_ready", b0.move_ready, 0);

    // vsync-synced instance: commit waits for a frame
    e.err   = 1'b0;
    e.board = 64'h1 << 60;
    e.jug   = 1'b1;
    e.st    = 2'b00;
    e.rdy   = 1'b1;
    sbq.push_back(e);
    b1.move_valid = 1'b1;
    b1.casilla    = 4'd15;
    @(negedge clk);
    b1.move_valid = 1'b0;
    seen = 1'b0;
    repeat (100) begin
      @(negedge clk);
      seen = seen | (b1.board != 64'd0);
    end
    chk("sync_hold", seen, 0);
    chk("sync_wait_rdy", b1.move_ready, 0);
    b1.vsync = 1'b0;
    n = 0;
    while (b1.board[63:60] != 4'd1 && n < 4) begin
      @(negedge clk);
      n++;
    end
    b1.vsync = 1'b1;
    g = sbq.pop_front();
    chk("sync_board", b1.board, g.board);
    chk("sync_jug", b1.jugador, g.jug);
    chk("sync_status", b1.status, g.st);
    chk("sync_ready", b1.move_ready, g.rdy);

    b1.new_game   = 1'b1;
    b1.move_valid = 1'b1;
    b1.casilla    = 4'd0;
    @(negedge clk);
    b1.new_game   = 1'b0;
    b1.move_valid = 1'b0;
    chk("ng_mv_ready", b1.move_ready, 0);
    repeat (3) @(negedge clk);
    chk("ng_mv_err", b1.move_err, 0);
    chk("ng_mv_wait", b1.move_ready, 0);
    chk("ng_mv_board", b1.board, 64'h1 << 60);

    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst2_board", b1.board, 0);
    chk("rst2_status", b1.status, 0);
    chk("rst2_jug", b1.jugador, 0);
    chk("rst2_ready", b1.move_ready, 1);
    chk("rst2_err", b1.move_err, 0);
    chk("rst2_board0", b0.board, 0);
    chk("rst2_ready0", b0.move_ready, 1);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
